// File: rtl/matvec_pkg.sv
// matvec_pkg: shared types, default widths and the saturating-add helper
// used by the matrix-vector engine.
package matvec_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int ACC_W_DEF  = 28;
  // Working width for the saturating adder; any accumulator up to 63 bits
  // fits with headroom, so the raw sum can never wrap before clamping.
  localparam int SAT_W      = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_X  = 3'd1,
    LOAD_W  = 3'd2,
    COMPUTE = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  // Add two sign-extended operands and clamp the result to the signed range
  // of an acc_w-bit accumulator.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a_i,
    input logic signed [SAT_W-1:0] b_i,
    input int unsigned             acc_w
  );
    logic signed [SAT_W-1:0] sum_s;
    logic signed [SAT_W-1:0] max_s;
    logic signed [SAT_W-1:0] min_s;
    sum_s = a_i + b_i;
    max_s = $signed((64'd1 << (acc_w - 32'd1)) - 64'd1);
    min_s = ~max_s;
    if (sum_s > max_s) begin
      sat_add = max_s;
    end else if (sum_s < min_s) begin
      sat_add = min_s;
    end else begin
      sat_add = sum_s;
    end
  endfunction

endpackage

// File: rtl/matvec_engine_mac.sv
// mac_sat_unit: combinational full-precision signed multiply followed by a
// saturating accumulate; the accumulator register lives in the caller.
module mac_sat_unit
  import matvec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] w_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [SAT_W-1:0]    sum_ext_s;

  // Product is exact at 2*DATA_W bits; the add is clamped to ACC_W bits.
  always_comb begin
    prod_s    = (2*DATA_W)'(x_i) * (2*DATA_W)'(w_i);
    sum_ext_s = sat_add(SAT_W'(acc_i), SAT_W'(prod_s), ACC_W);
    sum_o     = sum_ext_s[ACC_W-1:0];
  end

endmodule

// File: rtl/matvec_engine.sv
// matvec_engine: sequenced signed y = W*x with streamed operand load,
// optional weight reuse and a backpressured result stream (one row per beat).
// Optional build macro MATVEC_RELU_EN clamps negative results to zero on
// the output stream only.
module matvec_engine
  import matvec_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int ROWS   = 3,
  parameter  int COLS   = 3,
  parameter  int ACC_W  = 2*DATA_W,
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     reuse_w,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [ROW_W-1:0]         out_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

  state_t                   state_q, state_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     reuse_q, reuse_d;
  logic                     w_loaded_q, w_loaded_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;
  logic signed [ACC_W-1:0]  out_data_q, out_data_d;
  logic [ROW_W-1:0]         out_row_q, out_row_d;

  logic                     beat_s, out_hs_s, last_col_s, last_row_s;
  logic                     x_we_s, w_we_s;
  logic signed [ACC_W-1:0]  mac_sum_s;
  logic signed [ACC_W-1:0]  acc_out_s;

  // Operand storage; contents are only meaningful after a load.
  logic signed [DATA_W-1:0] x_q [COLS];
  logic signed [DATA_W-1:0] w_q [ROWS][COLS];

  mac_sat_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .acc_i (acc_q),
    .x_i   (x_q[col_q]),
    .w_i   (w_q[row_q][col_q]),
    .sum_o (mac_sum_s)
  );

  // Value presented on the result stream for the current accumulator.
  always_comb begin
`ifdef MATVEC_RELU_EN
    if (acc_q[ACC_W-1]) begin
      acc_out_s = {ACC_W{1'b0}};
    end else begin
      acc_out_s = acc_q;
    end
`else
    acc_out_s = acc_q;
`endif
  end

  // Sequencer: next state, counters, accumulator and stream controls.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    acc_d       = acc_q;
    reuse_d     = reuse_q;
    w_loaded_d  = w_loaded_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    x_we_s      = 1'b0;
    w_we_s      = 1'b0;
    beat_s      = in_valid & in_ready_q;
    out_hs_s    = out_valid_q & out_ready;
    last_col_s  = (col_q == COL_LAST);
    last_row_s  = (row_q == ROW_LAST);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_X;
          reuse_d = reuse_w;
          row_d   = {ROW_W{1'b0}};
          col_d   = {COL_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_X: begin
        if (beat_s) begin
          x_we_s = 1'b1;
          if (last_col_s) begin
            col_d = {COL_W{1'b0}};
            // Reuse is honoured only when a weight set survives in storage.
            if (reuse_q && w_loaded_q) begin
              state_d = COMPUTE;
              acc_d   = {ACC_W{1'b0}};
            end else begin
              state_d = LOAD_W;
            end
          end else begin
            col_d = col_q + COL_ONE;
          end
        end else begin
          state_d = LOAD_X;
        end
      end
      LOAD_W: begin
        if (beat_s) begin
          w_we_s = 1'b1;
          if (last_col_s) begin
            col_d = {COL_W{1'b0}};
            if (last_row_s) begin
              row_d      = {ROW_W{1'b0}};
              w_loaded_d = 1'b1;
              state_d    = COMPUTE;
              acc_d      = {ACC_W{1'b0}};
            end else begin
              row_d = row_q + ROW_ONE;
            end
          end else begin
            col_d = col_q + COL_ONE;
          end
        end else begin
          state_d = LOAD_W;
        end
      end
      COMPUTE: begin
        acc_d = mac_sum_s;
        if (last_col_s) begin
          col_d   = {COL_W{1'b0}};
          state_d = OUTPUT;
        end else begin
          col_d = col_q + COL_ONE;
        end
      end
      OUTPUT: begin
        // First OUTPUT cycle captures the result; out_valid follows a cycle later.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_out_s;
          out_row_d   = row_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (last_row_s) begin
            row_d   = {ROW_W{1'b0}};
            state_d = IDLE;
          end else begin
            row_d   = row_q + ROW_ONE;
            acc_d   = {ACC_W{1'b0}};
            state_d = COMPUTE;
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d = (state_d == LOAD_X) || (state_d == LOAD_W);
    busy_d     = (state_d != IDLE);
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= {ROW_W{1'b0}};
      col_q       <= {COL_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      reuse_q     <= 1'b0;
      w_loaded_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= {ACC_W{1'b0}};
      out_row_q   <= {ROW_W{1'b0}};
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      reuse_q     <= reuse_d;
      w_loaded_q  <= w_loaded_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
    end
  end

  // Operand storage writes; no reset so the arrays stay plain RAM-like flops.
  always_ff @(posedge clk) begin
    if (x_we_s) begin
      x_q[col_q] <= in_data;
    end
    if (w_we_s) begin
      w_q[row_q][col_q] <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign busy      = busy_q;
  // Pulses in the accepting cycle of the last row, while busy is still high.
  assign done      = out_hs_s & last_row_s;

endmodule
